// File: rtl/scan_ctrl_pkg.sv
// Shared encodings for the scan control unit: FSM states, command opcodes, scan modes
// and a lowest-set-bit helper used for channel iteration.
package scan_ctrl_pkg;

  typedef enum logic [3:0] {
    StIdle,
    StFetchCmd,
    StPop,
    StFetchDataWait,
    StFetchData,
    StWaitServo,
    StTrigger,
    StMeasure,
    StTxWait,
    StTxStrobe,
    StTxAck
  } state_t;

  typedef enum logic {
    ModeAuto   = 1'b0,
    ModeManual = 1'b1
  } mode_t;

  localparam logic [3:0] MANUAL_CMD = 4'h0;
  localparam logic [1:0] SET_ANGLE  = 2'h0;
  localparam logic [1:0] SET_MODE   = 2'h1;
  localparam logic [1:0] MEASURE    = 2'h2;
  localparam logic [1:0] SET_MASK   = 2'h3;

  // Index of the lowest set bit; 0 when the mask is empty.
  function automatic logic [2:0] first_set(input logic [7:0] m);
    logic [2:0] idx;
    idx = '0;
    for (int i = 7; i >= 0; i--) begin
      if (m[i]) idx = 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/sonar_sequencer.sv
// Fires enabled sonars in ascending order, one at a time, with a per-channel echo timeout,
// and buffers one distance byte per channel.
module sonar_sequencer
  import scan_ctrl_pkg::*;
#(
  parameter int unsigned NUM_CH         = 2,
  parameter int unsigned TIMEOUT_CYCLES = 2000000,
  parameter logic [7:0]  NO_ECHO        = 8'hFF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [NUM_CH-1:0]   ch_mask,
  input  logic [NUM_CH-1:0]   sonar_ready,
  input  logic [8*NUM_CH-1:0] sonar_distance,
  output logic [NUM_CH-1:0]   sonar_measure,
  output logic                done,
  output logic [8*NUM_CH-1:0] dist_buf
);

  localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT_CYCLES - 1);

  logic            active_q;
  logic [2:0]      ch_q;
  logic [7:0]      pend_q;
  logic [CntW-1:0] cnt_q;

  logic [7:0] mask8, ready8, src8, src_rest, trig8;
  logic [2:0] src_ch;
  logic       hit, expired, finish;

  always_comb begin
    mask8 = '0;
    mask8[NUM_CH-1:0] = ch_mask;
    ready8 = '0;
    ready8[NUM_CH-1:0] = sonar_ready;
    // Next channel comes from the fresh mask on start, else from what is still pending.
    src8     = start ? mask8 : pend_q;
    src_ch   = first_set(src8);
    trig8    = 8'h01 << src_ch;
    src_rest = src8 & ~trig8;
    // Ready is ignored during the trigger cycle itself.
    hit      = active_q && (sonar_measure == '0) && ready8[ch_q];
    expired  = active_q && (cnt_q == CntMax);
    finish   = hit || expired;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_q      <= 1'b0;
      ch_q          <= '0;
      pend_q        <= '0;
      cnt_q         <= '0;
      sonar_measure <= '0;
      done          <= 1'b0;
      dist_buf      <= '0;
    end else begin
      sonar_measure <= '0;
      done          <= 1'b0;
      if (active_q) cnt_q <= cnt_q + CntW'(1);
      if (finish) begin
        for (int i = 0; i < NUM_CH; i++) begin
          if (ch_q == 3'(i)) dist_buf[8*i +: 8] <= hit ? sonar_distance[8*i +: 8] : NO_ECHO;
        end
      end
      if (start || finish) begin
        if (src8 != '0) begin
          ch_q          <= src_ch;
          pend_q        <= src_rest;
          cnt_q         <= '0;
          active_q      <= 1'b1;
          sonar_measure <= trig8[NUM_CH-1:0];
        end else begin
          active_q <= 1'b0;
          done     <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/scan_control_unit.sv
// UART command decoder and frame transmitter for a multi-sonar servo scanner; the sonar
// firing sequence is delegated to sonar_sequencer.
module scan_control_unit
  import scan_ctrl_pkg::*;
#(
  parameter int unsigned NUM_CH         = 2,
  parameter int unsigned TIMEOUT_CYCLES = 2000000,
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
  parameter logic [7:0]  NO_ECHO        = 8'hFF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [7:0]          cmd,
  input  logic                rx_rdy,
  output logic                cmd_oen,
  input  logic                tx_rdy,
  output logic                data_wen,
  output logic [7:0]          data,
  input  logic [7:0]          servo_angle,
  input  logic                servo_cycle_done,
  output logic [7:0]          start_angle,
  output logic [7:0]          end_angle,
  input  logic [NUM_CH-1:0]   sonar_ready,
  input  logic [8*NUM_CH-1:0] sonar_distance,
  output logic [NUM_CH-1:0]   sonar_measure,
  output logic                busy
);

  state_t              state_q, pop_next_q;
  mode_t               mode_q;
  logic [NUM_CH-1:0]   ch_mask_q, tx_pend_q;
  logic [1:0]          op_q, tx_idx_q;
  logic [7:0]          angle_q;
  logic                seq_start, seq_done;
  logic [8*NUM_CH-1:0] dist_buf;
  logic [7:0]          pend8, pend_rest, dist_byte, tx_byte;
  logic [2:0]          tx_ch;
  logic [3:0]          lo_nib, hi_nib;

  assign seq_start = (state_q == StTrigger);
  assign busy      = (state_q != StIdle);

  sonar_sequencer #(
    .NUM_CH        (NUM_CH),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .NO_ECHO       (NO_ECHO)
  ) u_seq (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (seq_start),
    .ch_mask       (ch_mask_q),
    .sonar_ready   (sonar_ready),
    .sonar_distance(sonar_distance),
    .sonar_measure (sonar_measure),
    .done          (seq_done),
    .dist_buf      (dist_buf)
  );

  always_comb begin
    pend8 = '0;
    pend8[NUM_CH-1:0] = tx_pend_q;
    tx_ch     = first_set(pend8);
    pend_rest = pend8 & ~(8'h01 << tx_ch);
    dist_byte = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (tx_ch == 3'(i)) dist_byte = dist_buf[8*i +: 8];
    end
    case (tx_idx_q)
      2'd0:    tx_byte = SYNC_BYTE;
      2'd1:    tx_byte = angle_q;
      default: tx_byte = dist_byte;
    endcase
    lo_nib = (cmd[7:4] < cmd[3:0]) ? cmd[7:4] : cmd[3:0];
    hi_nib = (cmd[7:4] < cmd[3:0]) ? cmd[3:0] : cmd[7:4];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      pop_next_q  <= StIdle;
      mode_q      <= ModeAuto;
      ch_mask_q   <= '1;
      tx_pend_q   <= '0;
      op_q        <= SET_ANGLE;
      tx_idx_q    <= '0;
      angle_q     <= '0;
      cmd_oen     <= 1'b1;
      data_wen    <= 1'b1;
      data        <= '0;
      start_angle <= 8'h00;
      end_angle   <= 8'hFF;
    end else begin
      cmd_oen  <= 1'b1;
      data_wen <= 1'b1;
      case (state_q)
        StIdle: begin
          if (rx_rdy) state_q <= StFetchCmd;
          else if (mode_q == ModeAuto) state_q <= StWaitServo;
        end
        StFetchCmd: begin
          cmd_oen <= 1'b0;
          op_q    <= cmd[3:2];
          state_q <= StPop;
          if (cmd[7:4] != MANUAL_CMD) begin
            start_angle <= {lo_nib, 4'h0};
            end_angle   <= {hi_nib, 4'h0};
            pop_next_q  <= StIdle;
          end else begin
            case (cmd[3:2])
              SET_MODE: begin
                mode_q     <= mode_t'(cmd[0]);
                pop_next_q <= StIdle;
              end
              MEASURE: begin
                angle_q    <= servo_angle;
                pop_next_q <= StTrigger;
              end
              default: pop_next_q <= StFetchDataWait;
            endcase
          end
        end
        // Hold here until rx drops its valid so one byte is never consumed twice.
        StPop: if (!rx_rdy) state_q <= pop_next_q;
        StFetchDataWait: if (rx_rdy) state_q <= StFetchData;
        StFetchData: begin
          cmd_oen    <= 1'b0;
          pop_next_q <= StIdle;
          state_q    <= StPop;
          if (op_q == SET_ANGLE) begin
            start_angle <= cmd;
            end_angle   <= cmd;
          end else begin
            ch_mask_q <= cmd[NUM_CH-1:0];
          end
        end
        StWaitServo: begin
          if (servo_cycle_done) begin
            angle_q <= servo_angle;
            state_q <= StTrigger;
          end else if (rx_rdy) begin
            state_q <= StIdle;
          end
        end
        StTrigger: state_q <= StMeasure;
        StMeasure: begin
          if (seq_done) begin
            tx_idx_q  <= '0;
            tx_pend_q <= ch_mask_q;
            state_q   <= StTxWait;
          end
        end
        StTxWait: begin
          if (tx_rdy) begin
            data     <= tx_byte;
            data_wen <= 1'b0;
            state_q  <= StTxStrobe;
          end
        end
        StTxStrobe: begin
          if (tx_idx_q != 2'd2) tx_idx_q <= tx_idx_q + 2'd1;
          else tx_pend_q <= pend_rest[NUM_CH-1:0];
          state_q <= StTxAck;
        end
        StTxAck: begin
          if (!tx_rdy) begin
            state_q <= (tx_idx_q == 2'd2 && tx_pend_q == '0) ? StIdle : StTxWait;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_scan_control_unit.sv
// Directed bench for scan_control_unit with simple rx, tx, sonar and servo models.
module tb_scan_control_unit;

  localparam int NUM_CH = 2;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic [7:0]          cmd = '0;
  logic                rx_rdy = 1'b0;
  logic                cmd_oen;
  logic                tx_rdy;
  logic                data_wen;
  logic [7:0]          data;
  logic [7:0]          servo_angle = 8'h5A;
  logic                servo_cycle_done;
  logic [7:0]          start_angle, end_angle;
  logic [NUM_CH-1:0]   sonar_ready;
  logic [8*NUM_CH-1:0] sonar_distance;
  logic [NUM_CH-1:0]   sonar_measure;
  logic                busy;

  logic [7:0] dist_val [NUM_CH];
  int         dly [NUM_CH];
  bit         dead [NUM_CH];
  int         cd [NUM_CH];
  int         trig_cyc [NUM_CH];
  int         trig_q[$];
  logic [7:0] tx_q[$];
  int         pops = 0, wen_bad = 0, wen_run = 0, hold = 0, cyc = 0, scnt = 0;
  bit         servo_en = 0;
  int         passed = 0, total = 0;

  assign sonar_distance = {dist_val[1], dist_val[0]};

  always #5 clk = ~clk;

  scan_control_unit #(
    .NUM_CH        (NUM_CH),
    .TIMEOUT_CYCLES(100),
    .SYNC_BYTE     (8'hA5),
    .NO_ECHO       (8'hFF)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .cmd             (cmd),
    .rx_rdy          (rx_rdy),
    .cmd_oen         (cmd_oen),
    .tx_rdy          (tx_rdy),
    .data_wen        (data_wen),
    .data            (data),
    .servo_angle     (servo_angle),
    .servo_cycle_done(servo_cycle_done),
    .start_angle     (start_angle),
    .end_angle       (end_angle),
    .sonar_ready     (sonar_ready),
    .sonar_distance  (sonar_distance),
    .sonar_measure   (sonar_measure),
    .busy            (busy)
  );

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got 'h%0h, expected 'h%0h", name, act, exp);
  endtask

  task automatic bound_fail(input string name);
    total++;
    $display("FAIL %s: wait budget expired", name);
  endtask

  // Transmitter: capture each strobed byte, go busy for two cycles.
  initial begin
    tx_rdy = 1'b1;
    forever begin
      @(negedge clk);
      if (data_wen === 1'b0) begin
        tx_q.push_back(data);
        wen_run++;
        tx_rdy = 1'b0;
        hold = 2;
      end else begin
        if (wen_run > 1) wen_bad++;
        wen_run = 0;
        if (hold > 0) begin
          hold--;
          if (hold == 0) tx_rdy = 1'b1;
        end
      end
    end
  end

  // Sonars: one-cycle ready pulse dly[i] cycles after a trigger, unless dead.
  initial begin
    sonar_ready = '0;
    for (int i = 0; i < NUM_CH; i++) cd[i] = 0;
    forever begin
      @(negedge clk);
      cyc++;
      for (int i = 0; i < NUM_CH; i++) begin
        sonar_ready[i] = 1'b0;
        if (cd[i] > 0) begin
          cd[i]--;
          if (cd[i] == 0) sonar_ready[i] = 1'b1;
        end
        if (sonar_measure[i] === 1'b1) begin
          trig_q.push_back(i);
          trig_cyc[i] = cyc;
          if (!dead[i]) cd[i] = dly[i];
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (cmd_oen === 1'b0) pops++;
    end
  end

  initial begin
    servo_cycle_done = 1'b0;
    forever begin
      @(negedge clk);
      servo_cycle_done = 1'b0;
      if (servo_en) begin
        scnt++;
        if (scnt >= 40) begin
          scnt = 0;
          servo_cycle_done = 1'b1;
          servo_angle = servo_angle + 8'h10;
        end
      end
    end
  end

  task automatic send_cmd(input logic [7:0] b, input int extra_hold);
    int n;
    @(negedge clk);
    cmd = b;
    rx_rdy = 1'b1;
    n = 0;
    while (cmd_oen !== 1'b0 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 1000) bound_fail("rx pop");
    repeat (extra_hold) @(negedge clk);
    rx_rdy = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_bytes(input int n, input string name);
    int k;
    k = 0;
    while (tx_q.size() < n && k < 5000) begin
      @(negedge clk);
      k++;
    end
    if (k >= 5000) bound_fail(name);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, " cmd_oen"}, int'(cmd_oen), 1);
    chk({tag, " data_wen"}, int'(data_wen), 1);
    chk({tag, " data"}, int'(data), 'h00);
    chk({tag, " sonar_measure"}, int'(sonar_measure), 0);
    chk({tag, " start_angle"}, int'(start_angle), 'h00);
    chk({tag, " end_angle"}, int'(end_angle), 'hFF);
    chk({tag, " busy"}, int'(busy), 0);
  endtask

  typedef struct {
    logic [7:0] c;
    logic [7:0] d;
    bit         has_d;
    logic [7:0] s;
    logic [7:0] e;
  } win_vec_t;

  win_vec_t vecs [6];

  initial begin
    int n, k, gap, p0;
    vecs[0] = '{c: 8'h3C, d: 8'h00, has_d: 0, s: 8'h30, e: 8'hC0};
    vecs[1] = '{c: 8'hC3, d: 8'h00, has_d: 0, s: 8'h30, e: 8'hC0};
    vecs[2] = '{c: 8'h55, d: 8'h00, has_d: 0, s: 8'h50, e: 8'h50};
    vecs[3] = '{c: 8'hF1, d: 8'h00, has_d: 0, s: 8'h10, e: 8'hF0};
    vecs[4] = '{c: 8'h00, d: 8'h7B, has_d: 1, s: 8'h7B, e: 8'h7B};
    vecs[5] = '{c: 8'h1F, d: 8'h00, has_d: 0, s: 8'h10, e: 8'hF0};
    dist_val[0] = 8'h30;
    dist_val[1] = 8'h44;
    dly[0] = 5;
    dly[1] = 8;
    dead[0] = 0;
    dead[1] = 0;

    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;

    send_cmd(8'h05, 0);
    repeat (5) @(negedge clk);
    chk("manual idle busy", int'(busy), 0);

    // Single measurement, both channels.
    tx_q.delete();
    trig_q.delete();
    send_cmd(8'h08, 0);
    wait_bytes(4, "frame1");
    repeat (20) @(negedge clk);
    chk("frame1 len", tx_q.size(), 4);
    if (tx_q.size() >= 4) begin
      chk("frame1 sync", int'(tx_q[0]), 'hA5);
      chk("frame1 angle", int'(tx_q[1]), 'h5A);
      chk("frame1 d0", int'(tx_q[2]), 'h30);
      chk("frame1 d1", int'(tx_q[3]), 'h44);
    end
    chk("frame1 triggers", trig_q.size(), 2);
    if (trig_q.size() == 2) begin
      chk("frame1 first trig", trig_q[0], 0);
      chk("frame1 second trig", trig_q[1], 1);
    end
    chk("frame1 wen width", wen_bad, 0);

    for (int i = 0; i < 6; i++) begin
      send_cmd(vecs[i].c, 0);
      if (vecs[i].has_d) send_cmd(vecs[i].d, 0);
      chk($sformatf("win%0d start", i), int'(start_angle), int'(vecs[i].s));
      chk($sformatf("win%0d end", i), int'(end_angle), int'(vecs[i].e));
    end

    // Mask with only channel 1 enabled.
    send_cmd(8'h0C, 0);
    send_cmd(8'h02, 0);
    tx_q.delete();
    trig_q.delete();
    send_cmd(8'h08, 0);
    wait_bytes(3, "mask2 frame");
    repeat (30) @(negedge clk);
    chk("mask2 len", tx_q.size(), 3);
    if (tx_q.size() >= 3) begin
      chk("mask2 sync", int'(tx_q[0]), 'hA5);
      chk("mask2 d1", int'(tx_q[2]), 'h44);
    end
    chk("mask2 triggers", trig_q.size(), 1);
    if (trig_q.size() == 1) chk("mask2 trig ch", trig_q[0], 1);

    // Empty mask: header-only frame.
    send_cmd(8'h0C, 0);
    send_cmd(8'h00, 0);
    tx_q.delete();
    trig_q.delete();
    send_cmd(8'h08, 0);
    wait_bytes(2, "mask0 frame");
    repeat (30) @(negedge clk);
    chk("mask0 len", tx_q.size(), 2);
    chk("mask0 triggers", trig_q.size(), 0);

    // Channel 0 never answers.
    send_cmd(8'h0C, 0);
    send_cmd(8'h03, 0);
    dead[0] = 1;
    tx_q.delete();
    trig_q.delete();
    send_cmd(8'h08, 0);
    wait_bytes(4, "timeout frame");
    repeat (20) @(negedge clk);
    dead[0] = 0;
    chk("timeout len", tx_q.size(), 4);
    if (tx_q.size() >= 4) begin
      chk("timeout d0", int'(tx_q[2]), 'hFF);
      chk("timeout d1", int'(tx_q[3]), 'h44);
    end
    gap = trig_cyc[1] - trig_cyc[0];
    chk("timeout gap in 99..102", int'(gap >= 99 && gap <= 102), 1);

    // Auto mode, repeating frames.
    tx_q.delete();
    servo_en = 1;
    send_cmd(8'h04, 0);
    wait_bytes(12, "auto frames");
    if (tx_q.size() >= 12) begin
      chk("auto sync0", int'(tx_q[0]), 'hA5);
      chk("auto sync1", int'(tx_q[4]), 'hA5);
      chk("auto sync2", int'(tx_q[8]), 'hA5);
      chk("auto d1", int'(tx_q[7]), 'h44);
    end

    // Command raised mid-frame: served only after the frame, popped once.
    k = 0;
    while (tx_q.size() % 4 != 1 && k < 5000) begin
      @(negedge clk);
      k++;
    end
    if (k >= 5000) bound_fail("mid-frame sync");
    p0 = pops;
    cmd = 8'h05;
    rx_rdy = 1'b1;
    k = 0;
    while (cmd_oen !== 1'b0 && k < 1000) begin
      @(negedge clk);
      k++;
    end
    if (k >= 1000) bound_fail("mid-frame pop");
    chk("pop at frame boundary", tx_q.size() % 4, 0);
    repeat (5) @(negedge clk);
    rx_rdy = 1'b0;
    repeat (20) @(negedge clk);
    chk("single pop", pops - p0, 1);
    repeat (100) @(negedge clk);
    n = tx_q.size();
    repeat (100) @(negedge clk);
    chk("manual stops frames", tx_q.size(), n);
    chk("manual busy", int'(busy), 0);
    servo_en = 0;

    // Reset while in TX_ACK.
    tx_q.delete();
    send_cmd(8'h08, 0);
    k = 0;
    while (data_wen !== 1'b0 && k < 1000) begin
      @(negedge clk);
      k++;
    end
    if (k >= 1000) bound_fail("strobe before reset");
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async reset");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    tx_q.delete();
    servo_en = 1;
    wait_bytes(4, "post-reset frame");
    if (tx_q.size() >= 4) begin
      chk("post-reset sync", int'(tx_q[0]), 'hA5);
      chk("post-reset d0", int'(tx_q[2]), 'h30);
    end
    servo_en = 0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
